video_frame_capture: RTL and testbench

Synthesizable receiver for the pipeline's pixel-stream interface (vsync high = frame active, href high = pixel valid, one pixel per clk). It sits at the output of the image processor. It captures one frame, or consecutive frames, into a frame-buffer write port in raster order. It also measures the active width and height of each frame and flags timing errors.

---
 rtl/vid_pkg.sv | 44 ++++
 rtl/vid_sync_edge.sv | 39 +++
 rtl/video_frame_capture.sv | 189 ++++++++++++++++++
 tb/tb_video_frame_capture.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vid_pkg
//  Description : Shared types and helpers for the video frame capture block:
//                capture FSM state encoding, error-flag bit indices and the
//                {B,G,R} pixel pack function.
//  Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

    // Capture FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Bit positions inside err_flags
    localparam int c_ERR_LINE = 0;  // line length differs from first line
    localparam int c_ERR_SIZE = 1;  // measured size differs from nominal
    localparam int c_ERR_OVFL = 2;  // pixel outside the frame buffer window
    localparam int c_ERR_HREF = 3;  // href asserted while vsync low

    // Saturation limit of the 16-bit position counters
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Widest colour component the pack function supports
    localparam int c_MAX_DW = 16;

    // Pack three components of width dw into {B,G,R}, blue in the MSBs
    function automatic logic [3*c_MAX_DW-1:0] pack_bgr(
        input logic [c_MAX_DW-1:0] r,
        input logic [c_MAX_DW-1:0] g,
        input logic [c_MAX_DW-1:0] b,
        input int unsigned         dw
    );
        logic [3*c_MAX_DW-1:0] v;
        v = {32'd0, r} | ({32'd0, g} << dw) | ({32'd0, b} << (2 * dw));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : vid_sync_edge
//  Description : Registers vsync/href and produces start-of-frame, end-of-
//                frame and line-end pulses from the current vs. previous
//                sample. vsync history resets high so that a frame already
//                running when reset releases is never seen as a frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic href,
    output logic sof,
    output logic eof,
    output logic line_end
);

    logic r_vsync_d;
    logic r_href_d;

    // One-cycle history of the sync inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b1;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_href_d  <= href;
        end
    end

    assign sof      = ~r_vsync_d &  vsync;
    assign eof      =  r_vsync_d & ~vsync;
    assign line_end =  r_href_d  & ~href;

endmodule
`default_nettype wire

// File: rtl/video_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_capture
//  Description : Pixel-stream receiver. Captures one (or consecutive) frames
//                into a frame-buffer write port in raster order, measures
//                the active width/height of each frame and flags timing
//                errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_frame_capture
    import vid_pkg::*;
#(
    parameter int IMG_HDISP = 400,
    parameter int IMG_VDISP = 400,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_arm,
    input  logic                  cap_cont,
    input  logic                  pre_frame_vsync,
    input  logic                  pre_frame_href,
    input  logic [DATA_W-1:0]     pre_img_red,
    input  logic [DATA_W-1:0]     pre_img_green,
    input  logic [DATA_W-1:0]     pre_img_blue,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [3*DATA_W-1:0]   wr_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic [15:0]           meas_width,
    output logic [15:0]           meas_height,
    output logic [3:0]            err_flags,
    output logic [15:0]           frame_cnt
);

    localparam int                c_PIX_W  = 3 * DATA_W;
    localparam logic [15:0]       c_HDISP  = 16'(IMG_HDISP);
    localparam logic [15:0]       c_VDISP  = 16'(IMG_VDISP);
    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(IMG_HDISP);

    state_t              r_state;
    state_t              w_next;

    logic                w_sof;
    logic                w_eof;
    logic                w_line_end;

    // r_x doubles as the pixel count of the current line
    logic [15:0]         r_x;
    logic [15:0]         r_y;
    logic [15:0]         r_width;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_line_base;

    logic                w_in_capture;
    logic                w_pix_take;
    logic                w_in_window;
    logic                w_stray_href;
    logic [15:0]         w_x_inc;
    logic [15:0]         w_y_inc;
    logic [15:0]         w_fin_width;
    logic [15:0]         w_fin_height;
    logic [c_PIX_W-1:0]  w_pix;

    vid_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (pre_frame_vsync),
        .href     (pre_frame_href),
        .sof      (w_sof),
        .eof      (w_eof),
        .line_end (w_line_end)
    );

    assign w_in_capture = (r_state == ST_CAPTURE);
    assign w_pix_take   = w_in_capture & pre_frame_href & pre_frame_vsync;
    assign w_in_window  = (r_x < c_HDISP) && (r_y < c_VDISP);
    assign w_stray_href = pre_frame_href & ~pre_frame_vsync;
    assign w_x_inc      = (r_x == c_CNT_MAX) ? r_x : r_x + 16'd1;
    assign w_y_inc      = (r_y == c_CNT_MAX) ? r_y : r_y + 16'd1;

    // A line may finish on the same cycle vsync falls, so fold it in here
    assign w_fin_width  = (w_line_end && r_y == 16'd0) ? r_x : r_width;
    assign w_fin_height = w_line_end ? w_y_inc : r_y;

    assign w_pix = c_PIX_W'(pack_bgr(c_MAX_DW'(pre_img_red),
                                     c_MAX_DW'(pre_img_green),
                                     c_MAX_DW'(pre_img_blue),
                                     DATA_W));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; cap_arm only matters in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (cap_arm || cap_cont) w_next = ST_WAIT_SOF;
            ST_WAIT_SOF: if (w_sof)               w_next = ST_CAPTURE;
            ST_CAPTURE:  if (w_eof)               w_next = ST_DONE;
            ST_DONE:     w_next = cap_cont ? ST_WAIT_SOF : ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        busy       = (r_state == ST_WAIT_SOF) || (r_state == ST_CAPTURE);
        frame_done = (r_state == ST_DONE);
    end

    // Position counters, write port, measurements and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_width     <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            err_flags   <= '0;
            frame_cnt   <= '0;
        end else begin
            wr_en <= 1'b0;

            if (r_state == ST_WAIT_SOF && w_sof) begin
                r_x         <= '0;
                r_y         <= '0;
                r_width     <= '0;
                r_addr      <= '0;
                r_line_base <= '0;
                err_flags   <= '0;
            end

            if (w_pix_take) begin
                if (w_in_window) begin
                    wr_en   <= 1'b1;
                    wr_addr <= r_addr;
                    wr_data <= w_pix;
                    r_addr  <= r_addr + 1'b1;
                end else begin
                    err_flags[c_ERR_OVFL] <= 1'b1;
                end
                r_x <= w_x_inc;
            end

            // Line end: the first line sets the reference width
            if (w_in_capture && w_line_end) begin
                if (r_y == 16'd0) begin
                    r_width <= r_x;
                end else if (r_x != r_width) begin
                    err_flags[c_ERR_LINE] <= 1'b1;
                end
                r_y         <= w_y_inc;
                r_x         <= '0;
                r_line_base <= r_line_base + c_STRIDE;
                r_addr      <= r_line_base + c_STRIDE;
            end

            // End of frame: results become visible during the DONE cycle
            if (w_in_capture && w_eof) begin
                meas_width  <= w_fin_width;
                meas_height <= w_fin_height;
                frame_cnt   <= frame_cnt + 16'd1;
                if (w_fin_width != c_HDISP || w_fin_height != c_VDISP) begin
                    err_flags[c_ERR_SIZE] <= 1'b1;
                end
            end

            if (w_stray_href && (w_in_capture || r_state == ST_DONE)) begin
                err_flags[c_ERR_HREF] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_capture
//  Description : Self-checking bench for video_frame_capture using a small
//                frame geometry, random pixel data and a reference model
//                that derives writes, sizes and error flags from the
//                line lengths of each generated frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_frame_capture;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int DW = 8;
    localparam int AW = 8;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            cap_arm  = 1'b0;
    logic            cap_cont = 1'b0;
    logic            vsync    = 1'b0;
    logic            href     = 1'b0;
    logic [DW-1:0]   red      = '0;
    logic [DW-1:0]   green    = '0;
    logic [DW-1:0]   blue     = '0;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [3*DW-1:0] wr_data;
    logic            frame_done;
    logic            busy;
    logic [15:0]     meas_width;
    logic [15:0]     meas_height;
    logic [3:0]      err_flags;
    logic [15:0]     frame_cnt;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [3*DW-1:0] data;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  lens[0:31];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    video_frame_capture #(
        .IMG_HDISP (H),
        .IMG_VDISP (V),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cap_arm         (cap_arm),
        .cap_cont        (cap_cont),
        .pre_frame_vsync (vsync),
        .pre_frame_href  (href),
        .pre_img_red     (red),
        .pre_img_green   (green),
        .pre_img_blue    (blue),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .busy            (busy),
        .meas_width      (meas_width),
        .meas_height     (meas_height),
        .err_flags       (err_flags),
        .frame_cnt       (frame_cnt)
    );

    // Record every write strobe and frame_done pulse away from the clock edge
    always @(negedge clk) begin
        if (wr_en) got_q.push_back('{addr: wr_addr, data: wr_data});
        if (frame_done) done_cnt++;
    end

    // Expected error flags of a frame made of nl lines with lengths lens[]
    function automatic logic [3:0] model_err(input int nl);
        logic [3:0] e;
        e = 4'b0000;
        for (int y = 1; y < nl; y++) if (lens[y] != lens[0]) e[0] = 1'b1;
        if (lens[0] != H || nl != V) e[1] = 1'b1;
        for (int y = 0; y < nl; y++) begin
            if (y < V && lens[y] > H) e[2] = 1'b1;
            if (y >= V && lens[y] > 0) e[2] = 1'b1;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; cap_arm = 1'b0; cap_cont = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_arm();
        @(negedge clk); cap_arm = 1'b1;
        @(negedge clk); cap_arm = 1'b0;
    endtask

    task automatic frame_begin();
        repeat (4) begin @(negedge clk); vsync = 1'b0; href = 1'b0; end
        @(negedge clk); vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // stray=1 puts a pixel on the cycle vsync falls
    task automatic frame_end(input bit stray);
        @(negedge clk); vsync = 1'b0; href = stray;
        @(negedge clk); href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int y, input int len, input bit cap);
        for (int x = 0; x < len; x++) begin
            @(negedge clk);
            href  = 1'b1;
            red   = DW'($urandom);
            green = DW'($urandom);
            blue  = DW'($urandom);
            if (cap && x < H && y < V)
                exp_q.push_back('{addr: AW'(y * H + x), data: {blue, green, red}});
        end
        repeat (3) begin @(negedge clk); href = 1'b0; end
    endtask

    task automatic send_lines(input int y0, input int y1, input bit cap);
        for (int y = y0; y < y1; y++) send_line(y, lens[y], cap);
    endtask

    task automatic set_lens(input int w);
        for (int y = 0; y < 32; y++) lens[y] = w;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (wr_en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes got wr_en=%b done=%b busy=%b required 0", wr_en, frame_done, busy);
        end
        tests_run++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_wr_port got addr=%0h data=%0h required 0", wr_addr, wr_data);
        end
        tests_run++;
        if (meas_width !== 16'd0 || meas_height !== 16'd0 || err_flags !== 4'd0 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_status got w=%0d h=%0d err=%b cnt=%0d required 0", meas_width, meas_height, err_flags, frame_cnt);
        end
    endtask

    task automatic test_nominal();
        int  g0, d0, bad_i;
        bit  bad;
        do_reset();
        set_lens(H);
        exp_q.delete(); g0 = got_q.size(); d0 = done_cnt;
        pulse_arm();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL nominal_busy_armed got %b required 1", busy); end
        frame_begin(); send_lines(0, V, 1'b1); frame_end(1'b0);
        tests_run++;
        bad = (got_q.size() - g0 != exp_q.size()); bad_i = -1;
        for (int i = 0; !bad && i < exp_q.size(); i++) if (got_q[g0 + i] !== exp_q[i]) begin bad = 1'b1; bad_i = i; end
        if (bad) begin tests_failed++; $display("FAIL nominal_writes got %0d writes required %0d (first bad index %0d)", got_q.size() - g0, exp_q.size(), bad_i); end
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL nominal_done got %0d pulses required 1", done_cnt - d0); end
        tests_run++;
        if (meas_width !== 16'(H) || meas_height !== 16'(V) || err_flags !== 4'd0 || frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL nominal_status got w=%0d h=%0d err=%b cnt=%0d required %0d %0d 0000 1", meas_width, meas_height, err_flags, frame_cnt, H, V);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL nominal_idle got busy=%b required 0", busy); end
    endtask

    task automatic test_arm_mid_frame();
        int  g0, d0, bad_i;
        bit  bad;
        do_reset();
        set_lens(H);
        exp_q.delete(); g0 = got_q.size(); d0 = done_cnt;
        frame_begin(); send_lines(0, V / 2, 1'b0);
        pulse_arm();
        send_lines(V / 2, V, 1'b0); frame_end(1'b0);
        tests_run++;
        if (got_q.size() != g0 || done_cnt != d0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midarm_skip got writes=%0d done=%0d busy=%b required 0 0 1", got_q.size() - g0, done_cnt - d0, busy);
        end
        frame_begin(); send_lines(0, V, 1'b1); frame_end(1'b0);
        tests_run++;
        bad = (got_q.size() - g0 != exp_q.size()); bad_i = -1;
        for (int i = 0; !bad && i < exp_q.size(); i++) if (got_q[g0 + i] !== exp_q[i]) begin bad = 1'b1; bad_i = i; end
        if (bad) begin tests_failed++; $display("FAIL midarm_writes got %0d writes required %0d (first bad index %0d)", got_q.size() - g0, exp_q.size(), bad_i); end
        tests_run++;
        if (frame_cnt !== 16'd1 || done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL midarm_count got cnt=%0d done=%0d required 1 1", frame_cnt, done_cnt - d0);
        end
    endtask

    task automatic test_continuous();
        int  g0, d0, bad_i;
        bit  bad;
        do_reset();
        set_lens(H);
        d0 = done_cnt;
        @(negedge clk); cap_cont = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            exp_q.delete(); g0 = got_q.size();
            frame_begin(); send_lines(0, V, 1'b1);
            if (f == 3) cap_cont = 1'b0;
            frame_end(1'b0);
            tests_run++;
            bad = (got_q.size() - g0 != exp_q.size()); bad_i = -1;
            for (int i = 0; !bad && i < exp_q.size(); i++) if (got_q[g0 + i] !== exp_q[i]) begin bad = 1'b1; bad_i = i; end
            if (bad) begin tests_failed++; $display("FAIL cont_writes frame %0d got %0d writes required %0d (first bad index %0d)", f, got_q.size() - g0, exp_q.size(), bad_i); end
            tests_run++;
            if (frame_cnt !== 16'(f)) begin tests_failed++; $display("FAIL cont_frame_cnt got %0d required %0d", frame_cnt, f); end
        end
        tests_run++;
        if (done_cnt - d0 !== 3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cont_end got done=%0d busy=%b required 3 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int  g0, d0, bad_i;
        bit  bad;
        set_lens(H);
        exp_q.delete();
        pulse_arm();
        frame_begin(); send_lines(0, 5, 1'b1);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        tests_run++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_port got wr_en=%b addr=%0h data=%0h busy=%b done=%b required 0", wr_en, wr_addr, wr_data, busy, frame_done);
        end
        tests_run++;
        if (frame_cnt !== 16'd0 || meas_width !== 16'd0 || meas_height !== 16'd0 || err_flags !== 4'd0) begin
            tests_failed++;
            $display("FAIL rstmid_status got cnt=%0d w=%0d h=%0d err=%b required 0", frame_cnt, meas_width, meas_height, err_flags);
        end
        @(negedge clk); rst_n = 1'b1;
        g0 = got_q.size(); d0 = done_cnt; exp_q.delete();
        pulse_arm();
        send_lines(5, V, 1'b0); frame_end(1'b0);
        tests_run++;
        if (got_q.size() != g0 || done_cnt != d0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_no_sof got writes=%0d done=%0d busy=%b required 0 0 1", got_q.size() - g0, done_cnt - d0, busy);
        end
        frame_begin(); send_lines(0, V, 1'b1); frame_end(1'b0);
        tests_run++;
        bad = (got_q.size() - g0 != exp_q.size()); bad_i = -1;
        for (int i = 0; !bad && i < exp_q.size(); i++) if (got_q[g0 + i] !== exp_q[i]) begin bad = 1'b1; bad_i = i; end
        if (bad || frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL rstmid_next_frame got writes=%0d cnt=%0d required %0d 1 (first bad index %0d)", got_q.size() - g0, frame_cnt, exp_q.size(), bad_i);
        end
    endtask

    // Captures one frame of nl lines from lens[] and checks it against the model
    task automatic test_shaped_frame(input string name, input int nl, input bit stray);
        int         g0, d0, bad_i;
        bit         bad;
        logic [3:0] e;
        logic [15:0] c0;
        e = model_err(nl);
        if (stray) e[3] = 1'b1;
        c0 = frame_cnt;
        exp_q.delete(); g0 = got_q.size(); d0 = done_cnt;
        pulse_arm();
        frame_begin(); send_lines(0, nl, 1'b1); frame_end(stray);
        tests_run++;
        bad = (got_q.size() - g0 != exp_q.size()); bad_i = -1;
        for (int i = 0; !bad && i < exp_q.size(); i++) if (got_q[g0 + i] !== exp_q[i]) begin bad = 1'b1; bad_i = i; end
        if (bad) begin tests_failed++; $display("FAIL %s_writes got %0d writes required %0d (first bad index %0d)", name, got_q.size() - g0, exp_q.size(), bad_i); end
        tests_run++;
        if (meas_width !== 16'(lens[0]) || meas_height !== 16'(nl) || err_flags !== e) begin
            tests_failed++;
            $display("FAIL %s_status got w=%0d h=%0d err=%b required %0d %0d %b", name, meas_width, meas_height, err_flags, lens[0], nl, e);
        end
        tests_run++;
        if (frame_cnt !== c0 + 16'd1 || done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL %s_count got cnt=%0d done=%0d required %0d 1", name, frame_cnt, done_cnt - d0, c0 + 16'd1);
        end
    endtask

    task automatic test_short_line();
        do_reset();
        set_lens(H);
        lens[10] = H - 1;
        test_shaped_frame("short_line", V, 1'b0);
    endtask

    task automatic test_oversize();
        do_reset();
        set_lens(H + 2);
        test_shaped_frame("oversize", V + 1, 1'b0);
    endtask

    task automatic test_eof_pixel();
        do_reset();
        set_lens(H);
        test_shaped_frame("eof_pixel", V, 1'b1);
    endtask

    task automatic test_random_frames();
        int nl, w;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            nl = int'($urandom_range(V + 1, V - 1));
            w  = int'($urandom_range(H + 2, H - 2));
            set_lens(w);
            for (int y = 1; y < nl; y++)
                if ($urandom_range(7, 0) == 0) lens[y] = w + int'($urandom_range(2, 0)) - 1;
            test_shaped_frame("random", nl, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_arm_mid_frame();
        test_continuous();
        test_reset_mid();
        test_short_line();
        test_oversize();
        test_eof_pixel();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
